// File: rtl/vga_timing.sv
// Raster timing generator: pixel divider, h/v counters, sync/blank generation
// with a configurable delay line, and line/frame strobes for blanking-time updates.
module vga_timing #(
    parameter int HWIDTH = 12,
    parameter int VWIDTH = 12,
    parameter int HSIZE  = 640,
    parameter int HFP    = 16,
    parameter int HSYNC  = 96,
    parameter int HBP    = 48,
    parameter int VSIZE  = 480,
    parameter int VFP    = 10,
    parameter int VSYNC  = 2,
    parameter int VBP    = 33,
    parameter int CLKDIV = 4,
    parameter int DELAY  = 1,
    parameter bit HPOL   = 1'b0,
    parameter bit VPOL   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [HWIDTH-1:0] hdata,
    output logic [VWIDTH-1:0] vdata,
    output logic              pix_en,
    output logic              visible,
    output logic              hsync,
    output logic              vsync,
    output logic              blank,
    output logic              line_end,
    output logic              frame_end
);

    localparam int HTOTAL = HSIZE + HFP + HSYNC + HBP;
    localparam int VTOTAL = VSIZE + VFP + VSYNC + VBP;
    localparam int DIVW   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    localparam logic [DIVW-1:0]   DIV_LAST = DIVW'(CLKDIV - 1);
    localparam logic [HWIDTH-1:0] H_LAST   = HWIDTH'(HTOTAL - 1);
    localparam logic [VWIDTH-1:0] V_LAST   = VWIDTH'(VTOTAL - 1);
    localparam logic [VWIDTH-1:0] V_VIS_END = VWIDTH'(VSIZE - 1);

    // Sync window bounds carry one extra bit so an end equal to the total still fits.
    localparam logic [HWIDTH:0] H_VIS   = (HWIDTH+1)'(HSIZE);
    localparam logic [HWIDTH:0] HS_BEG  = (HWIDTH+1)'(HSIZE + HFP);
    localparam logic [HWIDTH:0] HS_END  = (HWIDTH+1)'(HSIZE + HFP + HSYNC);
    localparam logic [VWIDTH:0] V_VIS   = (VWIDTH+1)'(VSIZE);
    localparam logic [VWIDTH:0] VS_BEG  = (VWIDTH+1)'(VSIZE + VFP);
    localparam logic [VWIDTH:0] VS_END  = (VWIDTH+1)'(VSIZE + VFP + VSYNC);

    localparam logic [2:0] SYNC_IDLE = {~HPOL, ~VPOL, 1'b1};

    if ((HTOTAL - 1) >= (2 ** HWIDTH)) begin : g_hwidth_check
        $error("vga_timing: HTOTAL-1 does not fit in HWIDTH");
    end
    if ((VTOTAL - 1) >= (2 ** VWIDTH)) begin : g_vwidth_check
        $error("vga_timing: VTOTAL-1 does not fit in VWIDTH");
    end
    if (CLKDIV < 1 || DELAY < 0) begin : g_param_check
        $error("vga_timing: CLKDIV must be >= 1 and DELAY >= 0");
    end

    logic [DIVW-1:0] div;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would let hdata see this edge's pix_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div    <= '0;
            pix_en <= 1'b0;
            hdata  <= '0;
            vdata  <= '0;
        end else begin
            pix_en <= (div == DIV_LAST);
            div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
            if (pix_en) begin
                if (hdata == H_LAST) begin
                    hdata <= '0;
                    vdata <= (vdata == V_LAST) ? '0 : vdata + 1'b1;
                end else begin
                    hdata <= hdata + 1'b1;
                end
            end
        end
    end

    logic [HWIDTH:0] hx;
    logic [VWIDTH:0] vx;
    logic            raw_hsync;
    logic            raw_vsync;

    assign hx        = {1'b0, hdata};
    assign vx        = {1'b0, vdata};
    assign visible   = (hx < H_VIS) && (vx < V_VIS);
    assign raw_hsync = ((hx >= HS_BEG) && (hx < HS_END)) ? HPOL : ~HPOL;
    assign raw_vsync = ((vx >= VS_BEG) && (vx < VS_END)) ? VPOL : ~VPOL;

    assign line_end  = pix_en && (hdata == H_LAST);
    assign frame_end = line_end && (vdata == V_VIS_END);

    // Delay line runs every clk so it matches the layer's VRAM read latency in clks.
    if (DELAY == 0) begin : g_no_delay
        assign {hsync, vsync, blank} = {raw_hsync, raw_vsync, ~visible};
    end else begin : g_delay
        logic [2:0] pipe [DELAY];

        // NOTE: the stages are reset to the idle sync levels so no stale pulse
        // leaks out after reset; this is control state, not a data memory.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DELAY; i++) pipe[i] <= SYNC_IDLE;
            end else begin
                pipe[0] <= {raw_hsync, raw_vsync, ~visible};
                for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign {hsync, vsync, blank} = pipe[DELAY-1];
    end

endmodule
